// File: rtl/dmx_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmx_rx                                                       |
// | Description : DMX512 receiver: break/MAB detection, slot framing, errors.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmx_rx #(
   parameter int CLKS_PER_BIT = 80,
   parameter int BREAK_CLKS   = 1760,
   parameter int MAB_CLKS     = 160
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dmx_rxd,
   output logic       rx_valid,
   output logic [9:0] rx_slot,
   output logic [7:0] rx_data,
   output logic       frame_done,
   output logic [9:0] frame_slots,
   output logic       err_frame,
   output logic       err_overflow,
   output logic       rx_active
);

   localparam int c_LOW_W = $clog2(BREAK_CLKS + 1);
   localparam int c_CNT_W = $clog2(CLKS_PER_BIT + MAB_CLKS);

   localparam logic [c_LOW_W-1:0] c_BREAK    = c_LOW_W'(BREAK_CLKS);
   localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_BIT_M1   = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_MAB_M1   = c_CNT_W'(MAB_CLKS - 1);
   localparam logic [9:0]         c_MAX_SLOT = 10'd513;

   typedef enum logic [3:0] {
      ST_HUNT   = 4'd0,
      ST_BREAK  = 4'd1,
      ST_MAB    = 4'd2,
      ST_IDLE   = 4'd3,
      ST_START  = 4'd4,
      ST_DATA   = 4'd5,
      ST_STOP1  = 4'd6,
      ST_STOP2  = 4'd7,
      ST_BRKCHK = 4'd8
   } state_t;

   state_t               r_state;
   logic [1:0]           r_sync;
   logic                 r_rxd_d;
   logic [c_LOW_W-1:0]   r_low_cnt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [2:0]           r_bit;
   logic [7:0]           r_shift;
   logic [9:0]           r_slot_cnt;
   logic                 w_rxd_s;
   logic                 w_fall;

   assign w_rxd_s   = r_sync[1];
   assign w_fall    = r_rxd_d & ~w_rxd_s;
   assign rx_active = (r_state != ST_HUNT) && (r_state != ST_BREAK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync    <= 2'b11;
         r_rxd_d   <= 1'b1;
         r_low_cnt <= '0;
      end else begin
         r_sync  <= {r_sync[0], dmx_rxd};
         r_rxd_d <= w_rxd_s;
         if (w_rxd_s) begin
            r_low_cnt <= '0;
         end else if (r_low_cnt != c_BREAK) begin
            r_low_cnt <= r_low_cnt + c_LOW_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_HUNT;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_slot_cnt   <= '0;
         rx_valid     <= 1'b0;
         rx_slot      <= '0;
         rx_data      <= '0;
         frame_done   <= 1'b0;
         frame_slots  <= '0;
         err_frame    <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         frame_done   <= 1'b0;
         err_frame    <= 1'b0;
         err_overflow <= 1'b0;
         // A full-length low always wins and silently drops any byte in flight
         if (r_state != ST_BREAK && r_low_cnt == c_BREAK) begin
            r_state    <= ST_BREAK;
            r_slot_cnt <= '0;
            if (r_slot_cnt != 10'd0) begin
               frame_done  <= 1'b1;
               frame_slots <= r_slot_cnt;
            end
         end else begin
            case (r_state)
               ST_HUNT: begin
                  r_cnt <= '0;
               end
               ST_BREAK: begin
                  if (w_rxd_s) begin
                     r_state <= ST_MAB;
                     r_cnt   <= c_CNT_W'(1);
                  end
               end
               ST_MAB: begin
                  if (!w_rxd_s) begin
                     err_frame <= 1'b1;
                     r_state   <= ST_HUNT;
                  end else if (r_cnt == c_MAB_M1) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_W'(1);
                  end
               end
               ST_IDLE: begin
                  if (w_fall) begin
                     r_state <= ST_START;
                     r_cnt   <= '0;
                  end
               end
               ST_START: begin
                  if (r_cnt == c_HALF_M1) begin
                     r_cnt <= '0;
                     r_bit <= '0;
                     r_state <= w_rxd_s ? ST_IDLE : ST_DATA;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_W'(1);
                  end
               end
               ST_DATA: begin
                  if (r_cnt == c_BIT_M1) begin
                     r_cnt   <= '0;
                     r_shift <= {w_rxd_s, r_shift[7:1]};
                     r_bit   <= r_bit + 3'd1;
                     if (r_bit == 3'd7) begin
                        r_state <= ST_STOP1;
                     end
                  end else begin
                     r_cnt <= r_cnt + c_CNT_W'(1);
                  end
               end
               ST_STOP1, ST_STOP2: begin
                  if (r_cnt == c_BIT_M1) begin
                     r_cnt <= '0;
                     if (!w_rxd_s) begin
                        // An all-zero byte with a low stop may be the start of a break
                        if (r_shift == 8'h00) begin
                           r_state <= ST_BRKCHK;
                        end else begin
                           err_frame <= 1'b1;
                           r_state   <= ST_HUNT;
                        end
                     end else if (r_state == ST_STOP1) begin
                        r_state <= ST_STOP2;
                     end else begin
                        r_state <= ST_IDLE;
                        if (r_slot_cnt == c_MAX_SLOT) begin
                           err_overflow <= 1'b1;
                        end else begin
                           rx_valid   <= 1'b1;
                           rx_slot    <= r_slot_cnt;
                           rx_data    <= r_shift;
                           r_slot_cnt <= r_slot_cnt + 10'd1;
                        end
                     end
                  end else begin
                     r_cnt <= r_cnt + c_CNT_W'(1);
                  end
               end
               ST_BRKCHK: begin
                  if (w_rxd_s) begin
                     err_frame <= 1'b1;
                     r_state   <= ST_HUNT;
                  end
               end
               default: begin
                  r_state <= ST_HUNT;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmx_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_dmx_rx                                                    |
// | Description : Scoreboard bench for dmx_rx; timing scaled down by 10.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dmx_rx;

   // 10x faster than the 20 MHz defaults so 515-slot packets stay short
   localparam int c_CPB   = 8;
   localparam int c_BRK   = 176;
   localparam int c_MAB   = 16;
   localparam int c_K_VALID = 0;
   localparam int c_K_DONE  = 1;
   localparam int c_K_ERR   = 2;
   localparam int c_K_OVF   = 3;

   typedef struct {
      int kind;
      int slot;
      int data;
   } evt_t;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       dmx_rxd = 1'b1;
   logic       rx_valid;
   logic [9:0] rx_slot;
   logic [7:0] rx_data;
   logic       frame_done;
   logic [9:0] frame_slots;
   logic       err_frame;
   logic       err_overflow;
   logic       rx_active;

   evt_t exp_q[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   tb_slots = 0;

   always #5 clk = ~clk;

   dmx_rx #(
      .CLKS_PER_BIT (c_CPB),
      .BREAK_CLKS   (c_BRK),
      .MAB_CLKS     (c_MAB)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dmx_rxd      (dmx_rxd),
      .rx_valid     (rx_valid),
      .rx_slot      (rx_slot),
      .rx_data      (rx_data),
      .frame_done   (frame_done),
      .frame_slots  (frame_slots),
      .err_frame    (err_frame),
      .err_overflow (err_overflow),
      .rx_active    (rx_active)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input int kind, input int slot, input int data);
      evt_t e;
      e.kind = kind;
      e.slot = slot;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic line(input logic v, input int n);
      dmx_rxd = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop1);
      line(1'b0, c_CPB);
      for (int i = 0; i < 8; i++) line(b[i], c_CPB);
      line(stop1, c_CPB);
      line(1'b1, c_CPB);
   endtask

   task automatic send_valid(input logic [7:0] b);
      if (tb_slots <= 512) begin
         push(c_K_VALID, tb_slots, int'(b));
         tb_slots++;
      end else begin
         push(c_K_OVF, 0, 0);
      end
      send_byte(b, 1'b1);
   endtask

   task automatic send_break(input int low, input int mab);
      if (tb_slots > 0) push(c_K_DONE, tb_slots, 0);
      tb_slots = 0;
      line(1'b0, low);
      line(1'b1, mab);
   endtask

   task automatic drain(input string tag);
      int budget;
      budget = 500;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   always @(negedge clk) begin : p_monitor
      int   nstrb;
      int   kind;
      evt_t e;
      nstrb = int'(rx_valid) + int'(frame_done) + int'(err_frame) + int'(err_overflow);
      if (nstrb != 0) begin
         kind = rx_valid ? c_K_VALID : frame_done ? c_K_DONE : err_frame ? c_K_ERR : c_K_OVF;
         chk("strobe_exclusive", nstrb, 1);
         if (exp_q.size() == 0) begin
            chk("expected_pending", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == c_K_VALID && e.kind == c_K_VALID) begin
               chk("rx_slot", rx_slot, e.slot);
               chk("rx_data", rx_data, e.data);
            end
            if (kind == c_K_DONE && e.kind == c_K_DONE) begin
               chk("frame_slots", frame_slots, e.slot);
            end
         end
      end
   end

   initial begin : p_watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : p_main
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_slot", rx_slot, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_slots", frame_slots, 0);
      chk("rst_err_frame", err_frame, 0);
      chk("rst_err_overflow", err_overflow, 0);
      chk("rst_rx_active", rx_active, 0);
      rst_n = 1'b1;
      line(1'b1, 20);

      // Byte with no preceding break must be ignored
      send_byte(8'h55, 1'b1);
      line(1'b1, 20);
      chk("nobreak_active", rx_active, 0);
      drain("nobreak_drain");

      // Basic packet: 00, 12, FF closed by the next break
      send_break(200, 24);
      chk("mab_active", rx_active, 1);
      send_valid(8'h00);
      send_valid(8'h12);
      send_valid(8'hFF);
      send_break(200, 24);
      drain("packet_drain");

      // 60 us low (scaled): framing error, back to hunting, no frame_done
      push(c_K_ERR, 0, 0);
      line(1'b0, 120);
      line(1'b1, 50);
      chk("shortbrk_active", rx_active, 0);
      send_byte(8'h44, 1'b1);
      line(1'b1, 20);
      drain("shortbrk_drain");

      // Bad stop on non-zero byte; later bytes ignored until next break
      send_break(200, 24);
      send_valid(8'h00);
      push(c_K_ERR, 0, 0);
      send_byte(8'h5A, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      chk("stopfail_active", rx_active, 0);
      drain("stopfail_drain");

      // Short glitch in IDLE is rejected; packet stays in sync
      send_break(200, 24);
      line(1'b0, 2);
      line(1'b1, 40);
      chk("glitch_active", rx_active, 1);
      send_valid(8'h33);
      drain("glitch_drain");

      // Reset in the middle of a byte
      line(1'b0, c_CPB);
      line(1'b1, c_CPB);
      line(1'b0, c_CPB);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_frame_slots", frame_slots, 0);
      chk("midrst_rx_slot", rx_slot, 0);
      chk("midrst_rx_data", rx_data, 0);
      chk("midrst_rx_active", rx_active, 0);
      rst_n = 1'b1;
      tb_slots = 0;
      line(1'b1, 6 * c_CPB);
      send_byte(8'h66, 1'b1);
      chk("postrst_active", rx_active, 0);
      drain("midrst_drain");

      // 515 slots: 513 valid, two overflow, frame_slots = 513
      send_break(200, 24);
      for (int i = 0; i < 515; i++) begin
         send_valid(8'(i * 7 + 3));
      end
      chk("ovf_slots_model", tb_slots, 513);
      send_break(200, 24);
      line(1'b1, 30);
      drain("overflow_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
